pc_fetch_sequencer: RTL and testbench

// Sequences the 16-bit program counter and instruction fetch for the pipeline.

---
 rtl/pc_fetch_sequencer.sv | 118 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_fetch_sequencer: PC register and instruction fetch sequencing for IF  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pc_fetch_sequencer #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  PC_INC   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                halt,
  input  logic                imem_ready,
  input  logic [15:0]         imem_rdata,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                fetch_valid,
  output logic [15:0]         instr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus,
  output logic                flush,
  output logic                halted,
  output logic [15:0]         fetch_count
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(PC_INC);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [15:0]         instr_q, instr_q_nxt;
  logic                flush_nxt;

  assign imem_addr = pc;
  assign pc_plus   = pc + PC_STEP;
  assign halted    = (state == HALT);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_q_nxt = instr_q;
    flush_nxt   = 1'b0;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    instr       = instr_q;

    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        instr    = imem_rdata;
        if (imem_ready) begin
          if (stall) begin
            instr_q_nxt = imem_rdata;
            state_nxt   = HOLD;
          end else begin
            fetch_valid = 1'b1;
            pc_nxt      = pc_plus;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          fetch_valid = 1'b1;
          pc_nxt      = pc_plus;
          state_nxt   = REQ;
        end
      end
      default: ;
    endcase

    // Redirect beats halt (a halt alongside a redirect is on the wrong path); HALT ignores both.
    if (state != HALT) begin
      if (redirect_valid) begin
        fetch_valid = 1'b0;
        pc_nxt      = redirect_pc;
        instr_q_nxt = '0;
        flush_nxt   = 1'b1;
        state_nxt   = REQ;
      end else if (halt) begin
        fetch_valid = 1'b0;
        pc_nxt      = pc;
        instr_q_nxt = instr_q;
        state_nxt   = HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr_q     <= '0;
      flush       <= 1'b0;
      fetch_count <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr_q <= instr_q_nxt;
      flush   <= flush_nxt;
      if (fetch_valid && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// Scoreboard bench for pc_fetch_sequencer: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, redirect_valid = 1'b0, halt = 1'b0, imem_ready = 1'b0;
  logic [15:0] redirect_pc = '0, imem_rdata = '0;
  logic        imem_req, fetch_valid, flush, halted;
  logic [15:0] imem_addr, instr, pc, pc_plus, fetch_count;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .fetch_valid(fetch_valid), .instr(instr), .pc(pc), .pc_plus(pc_plus),
    .flush(flush), .halted(halted), .fetch_count(fetch_count)
  );

  typedef struct {
    logic        fv;
    logic        req;
    logic [15:0] pc;
    logic        flush;
    logic        halted;
    logic [15:0] cnt;
  } status_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc_plus;
  } fetch_t;

  status_t stq[$];
  fetch_t  fq[$];
  int      n_cmp = 0;
  int      n_err = 0;
  bit      mon_on = 1'b0;

  // Reference model: what the fetch front end "knows" between cycles.
  logic [15:0] m_pc;
  logic        m_booting, m_holding, m_frozen, m_flush_due;
  logic [15:0] m_buf;
  int          m_count;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_on && stq.size() > 0) begin
      status_t s;
      s = stq.pop_front();
      check("fetch_valid", 32'(fetch_valid), 32'(s.fv));
      check("imem_req",    32'(imem_req),    32'(s.req));
      check("pc",          32'(pc),          32'(s.pc));
      check("imem_addr",   32'(imem_addr),   32'(s.pc));
      check("flush",       32'(flush),       32'(s.flush));
      check("halted",      32'(halted),      32'(s.halted));
      check("fetch_count", 32'(fetch_count), 32'(s.cnt));
      if (fetch_valid) begin
        if (fq.size() == 0) begin
          check("unexpected_fetch", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          fetch_t f;
          f = fq.pop_front();
          check("fetch_pc",      32'(pc),      32'(f.pc));
          check("fetch_instr",   32'(instr),   32'(f.instr));
          check("fetch_pc_plus", 32'(pc_plus), 32'(f.pc_plus));
        end
      end
    end
  end

  function automatic void model_reset();
    m_pc        = 16'h0000;
    m_booting   = 1'b1;
    m_holding   = 1'b0;
    m_frozen    = 1'b0;
    m_flush_due = 1'b0;
    m_buf       = '0;
    m_count     = 0;
  endfunction

  task automatic step(input logic s, input logic rv, input logic [15:0] rpc,
                      input logic h, input logic rdy, input logic [15:0] rd);
    status_t st;
    logic    delivers;
    stall = s; redirect_valid = rv; redirect_pc = rpc; halt = h;
    imem_ready = rdy; imem_rdata = rd;

    // An instruction leaves this cycle only if nothing higher-priority intervenes.
    delivers = !m_frozen && !m_booting && !rv && !h && !s && (m_holding || rdy);
    st.fv     = delivers;
    st.req    = !m_frozen && !m_booting && !m_holding;
    st.pc     = m_pc;
    st.flush  = m_flush_due;
    st.halted = m_frozen;
    st.cnt    = 16'(m_count);
    stq.push_back(st);
    if (delivers) begin
      fetch_t f;
      f.pc      = m_pc;
      f.instr   = m_holding ? m_buf : rd;
      f.pc_plus = 16'((32'(m_pc) + 2) % 65536);
      fq.push_back(f);
      if (m_count < 65535) m_count++;
    end

    m_flush_due = 1'b0;
    if (!m_frozen) begin
      if (rv) begin
        m_pc = rpc; m_booting = 1'b0; m_holding = 1'b0; m_buf = '0; m_flush_due = 1'b1;
      end else if (h) begin
        m_frozen = 1'b1;
      end else if (m_booting) begin
        m_booting = 1'b0;
      end else if (delivers) begin
        m_pc = 16'((32'(m_pc) + 2) % 65536);
        m_holding = 1'b0;
      end else if (!m_holding && rdy && s) begin
        m_holding = 1'b1;
        m_buf = rd;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if (fq.size() != 0) begin
      check("missed_fetches", 32'(fq.size()), 32'd0);
      fq.delete();
    end
    mon_on = 1'b0;
    stq.delete();
    stall = 1'b0; redirect_valid = 1'b0; halt = 1'b0; imem_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_pc",          32'(pc),          32'h0000);
    check("rst_imem_addr",   32'(imem_addr),   32'h0000);
    check("rst_pc_plus",     32'(pc_plus),     32'h0002);
    check("rst_imem_req",    32'(imem_req),    32'd0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_flush",       32'(flush),       32'd0);
    check("rst_halted",      32'(halted),      32'd0);
    check("rst_fetch_count", 32'(fetch_count), 32'd0);
    check("rst_instr",       32'(instr),       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    mon_on = 1'b1;
  endtask

  initial begin
    int frozen_cycles;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Boot, then three back-to-back fetches.
    step(0, 0, 16'h0, 0, 0, 16'h0);
    step(0, 0, 16'h0, 0, 1, 16'hA001);
    step(0, 0, 16'h0, 0, 1, 16'hA002);
    step(0, 0, 16'h0, 0, 1, 16'hA003);
    // Captured while stalled, delivered when stall drops.
    step(1, 0, 16'h0, 0, 1, 16'hB0B0);
    step(1, 0, 16'h0, 0, 1, 16'hDEAD);
    step(1, 0, 16'h0, 0, 0, 16'hDEAD);
    step(0, 0, 16'h0, 0, 1, 16'hDEAD);
    step(0, 0, 16'h0, 0, 0, 16'h0);
    // Redirect while waiting, then redirect together with halt.
    step(0, 1, 16'h0100, 0, 0, 16'h0);
    step(0, 0, 16'h0, 0, 0, 16'h0);
    step(0, 0, 16'h0, 0, 1, 16'hC100);
    step(0, 1, 16'h0200, 1, 1, 16'hC101);
    step(0, 0, 16'h0, 0, 1, 16'hC200);
    // Halt freezes; redirect and stall are ignored.
    step(0, 0, 16'h0, 1, 1, 16'hC202);
    step(0, 1, 16'h0300, 0, 1, 16'hC203);
    step(1, 0, 16'h0, 0, 1, 16'hC204);
    step(0, 0, 16'h0, 0, 1, 16'hC205);
    do_reset();
    // Wrap-around past FFFE.
    step(0, 1, 16'hFFFE, 0, 0, 16'h0);
    step(0, 0, 16'h0, 0, 1, 16'hE0FE);
    step(0, 0, 16'h0, 0, 1, 16'hE000);
    step(0, 0, 16'h0, 0, 1, 16'hE002);

    // Randomized traffic; a frozen model is revived by reset after a few cycles.
    frozen_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0), 16'($urandom),
           1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 2) != 0), 16'($urandom));
      if (m_frozen) frozen_cycles++;
      if (frozen_cycles > 4) begin
        frozen_cycles = 0;
        do_reset();
      end
    end

    // Drive fetch_count into saturation.
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      step(0, 0, 16'h0, 0, 1, 16'($urandom));
    end
    step(0, 0, 16'h0, 0, 0, 16'h0);

    mon_on = 1'b0;
    check("fetch_queue_drained", 32'(fq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
